// File: rtl/md5_arith_pkg.sv
// md5_arith_pkg: word/slice widths and FSM encoding shared by the sliced MD5 adder and subtractor.
package md5_arith_pkg;
  localparam int WORD_W = 32;
  localparam int SLICE_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/sub8.sv
// sub8: one-slice combinational subtract, {bo, d} = a - b - bi.
module sub8 #(
  parameter int W = md5_arith_pkg::SLICE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo
);
  // The extra top bit of the W+1 wide difference is the borrow.
  assign {bo, d} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
endmodule

// File: rtl/sub32_serial.sv
// sub32_serial: iterative a - b - bi, one SLICE-bit slice per clock through a single shared sub8.
module sub32_serial
  import md5_arith_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo
);
  localparam int SL = (SLICE == 0) ? 1 : SLICE;
  localparam int NSLICE = (WIDTH / SL < 1) ? 1 : WIDTH / SL;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  if (SLICE == 0 || WIDTH % SL != 0) begin : g_bad_cfg
    $fatal(1, "sub32_serial: WIDTH must be a nonzero multiple of SLICE");
  end

  state_e state_q, state_d;
  logic [NSLICE-1:0][SL-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [IW-1:0] idx_q, idx_d;
  logic brw_q, brw_d, bo_q, bo_d;
  logic [SL-1:0] s_d;
  logic s_bo;

  sub8 #(.W(SL)) u_sub8 (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .bi (brw_q),
    .d  (s_d),
    .bo (s_bo)
  );

  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    diff_d = diff_q;
    idx_d = idx_q;
    brw_d = brw_q;
    bo_d = bo_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        brw_d = bi;
        idx_d = '0;
        state_d = RUN;
      end
      RUN: begin
        diff_d[idx_q] = s_d;
        brw_d = s_bo;
        idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        bo_d = (idx_q == LAST) ? s_bo : bo_q;
        state_d = (idx_q == LAST) ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      diff_q <= '0;
      idx_q <= '0;
      brw_q <= 1'b0;
      bo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      diff_q <= diff_d;
      idx_q <= idx_d;
      brw_q <= brw_d;
      bo_q <= bo_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff = diff_q;
  assign bo = bo_q;
endmodule

// File: tb/tb_sub32_serial.sv
// tb_sub32_serial: directed vector table, backpressure/reset sequences and random ops against an integer model.
module tb_sub32_serial;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, bi = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, bo;
  logic [31:0] diff;
  int pass_n = 0, tot_n = 0, acc_n = 0, hs_n = 0;

  typedef struct {
    logic [31:0] a, b;
    logic bi;
    logic [31:0] d;
    logic bo;
    int hold;
  } vec_t;
  vec_t vt[8];

  sub32_serial dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bo(bo)
  );

  always #5 clk = ~clk;

  // Handshakes are counted at the negedge before the edge that completes them.
  always @(negedge clk) if (rst_n) begin
    if (in_valid && in_ready) acc_n++;
    if (out_valid && out_ready) hs_n++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [32:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic c);
    longint d;
    d = longint'(x) - longint'(y) - longint'(c);
    return {d < 0, d[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hold < 0: out_ready already high when DONE is entered.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbi,
                       input logic [31:0] ed, input logic eb, input int hold,
                       input logic chk_lat, input string nm);
    int lat;
    logic [31:0] sd;
    logic sb;
    step();
    in_valid = 1'b1; a = ta; b = tb_; bi = tbi;
    step();
    in_valid = 1'b0; a = $urandom; b = $urandom; bi = 1'($urandom);
    if (hold < 0) out_ready = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      chk({nm, " timeout"}, 64'(out_valid), 64'd1);
      out_ready = 1'b0;
      return;
    end
    if (chk_lat) chk({nm, " latency"}, 64'(lat), 64'd4);
    chk({nm, " diff"}, 64'(diff), 64'(ed));
    chk({nm, " bo"}, 64'(bo), 64'(eb));
    sd = diff;
    sb = bo;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom);
      a = $urandom; b = $urandom; bi = 1'($urandom);
      @(negedge clk);
      chk({nm, " hold"}, {31'd0, out_valid, sb, diff}, {31'd0, 1'b1, bo, sd});
      chk({nm, " hold ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk({nm, " drop"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [32:0] r;
    logic [31:0] ra, rb;
    logic rbi;
    vt[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 0};
    vt[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 0};
    vt[2] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1};
    vt[3] = '{32'h0100_0000, 32'h0000_0001, 1'b0, 32'h00FF_FFFF, 1'b0, 0};
    vt[4] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 2};
    vt[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 10};
    vt[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, -1};
    vt[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 3};
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {29'd0, in_ready, out_valid, bo, diff}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    rst_n = 1'b1;
    foreach (vt[i]) do_op(vt[i].a, vt[i].b, vt[i].bi, vt[i].d, vt[i].bo, vt[i].hold, 1'b1, $sformatf("vec%0d", i));
    // Asynchronous reset two slices into an operation.
    step();
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0; bi = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("partial diff", 64'(diff[15:0]), 64'h0000_FFFF);
    #2 rst_n = 1'b0;
    #1 chk("mid reset", {29'd0, in_ready, out_valid, bo, diff}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    step();
    rst_n = 1'b1;
    acc_n = 0;
    hs_n = 0;
    do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 32'hD2FF_CEE2, 1'b0, 0, 1'b1, "after reset");
    for (int n = 0; n < 3000; n++) begin
      repeat ($urandom_range(0, 2)) step();
      ra = $urandom;
      rb = (n % 8 == 0) ? ra : $urandom;
      rbi = 1'($urandom);
      r = ref_sub(ra, rb, rbi);
      do_op(ra, rb, rbi, r[31:0], r[32], int'($urandom_range(0, 3)) - 1, 1'b0, "rand");
    end
    chk("op count", 64'(hs_n), 64'(acc_n));
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
